lane_merge2: RTL and testbench

- Downstream merge stage for the two parallel sub2 output lanes (instance suffixes _i0 / _i1) produced at top level.
- Accepts one valid/ready stream per lane and buffers each lane in a DEPTH-entry FIFO.
- Merges the two lanes onto one registered output stream using round-robin arbitration.
- Tags every output word with its source lane; order within a lane is preserved.

---
 rtl/lane_merge2.sv | 116 +++++++++++
 tb/tb_lane_merge2.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_merge2.sv
// Two-lane merge: each valid/ready lane is buffered in its own FIFO, then the
// lanes are merged round-robin onto one registered, source-tagged output.
module lane_merge2 #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [DW-1:0]              i_sig_dat_i0,
    input  logic                       i_sig_vld_i0,
    output logic                       o_sig_rdy_i0,
    input  logic [DW-1:0]              i_sig_dat_i1,
    input  logic                       i_sig_vld_i1,
    output logic                       o_sig_rdy_i1,
    output logic [DW-1:0]              o_sig_dat,
    output logic                       o_sig_src,
    output logic                       o_sig_vld,
    input  logic                       i_sig_rdy,
    output logic [$clog2(DEPTH):0]     o_cnt_i0,
    output logic [$clog2(DEPTH):0]     o_cnt_i1
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DW-1:0] mem_p0 [2][DEPTH];
    logic [AW-1:0] wp_p0  [2];
    logic [AW-1:0] rp_p0  [2];
    logic [CW-1:0] cnt_p0 [2];
    logic [DW-1:0] din    [2];
    logic [1:0]    vin;
    logic [1:0]    rdy;
    logic [1:0]    ne;
    logic [1:0]    push;
    logic [1:0]    pop;
    logic          load;
    logic          gnt;
    logic          last_gnt;
    logic [DW-1:0] head;

    logic [DW-1:0] dat_p1;
    logic          src_p1;
    logic          vld_p1;

    assign din[0] = i_sig_dat_i0;
    assign din[1] = i_sig_dat_i1;
    assign vin    = {i_sig_vld_i1, i_sig_vld_i0};

    always_comb begin
        rdy  = '0;
        ne   = '0;
        push = '0;
        for (int n = 0; n < 2; n++) begin
            rdy[n]  = (cnt_p0[n] != FULL);
            ne[n]   = (cnt_p0[n] != '0);
            push[n] = vin[n] && rdy[n];
        end
    end

    // Lane 1 wins only when lane 0 is empty or lane 0 was served last.
    assign load   = (!vld_p1 || i_sig_rdy) && (ne[0] || ne[1]);
    assign gnt    = ne[1] && (!ne[0] || !last_gnt);
    assign pop[0] = load && !gnt;
    assign pop[1] = load && gnt;
    assign head   = mem_p0[gnt][rp_p0[gnt]];

    // Stage p0: per-lane FIFOs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int n = 0; n < 2; n++) begin
                wp_p0[n]  <= '0;
                rp_p0[n]  <= '0;
                cnt_p0[n] <= '0;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (push[n]) wp_p0[n] <= wp_p0[n] + 1'b1;
                if (pop[n])  rp_p0[n] <= rp_p0[n] + 1'b1;
                cnt_p0[n] <= cnt_p0[n] + CW'(push[n]) - CW'(pop[n]);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        for (int n = 0; n < 2; n++) begin
            if (push[n]) mem_p0[n][wp_p0[n]] <= din[n];
        end
    end

    // Stage p1: registered merged output
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            dat_p1   <= '0;
            src_p1   <= 1'b0;
            vld_p1   <= 1'b0;
            last_gnt <= 1'b1;
        end else if (load) begin
            dat_p1   <= head;
            src_p1   <= gnt;
            vld_p1   <= 1'b1;
            last_gnt <= gnt;
        end else if (i_sig_rdy) begin
            vld_p1   <= 1'b0;
        end
    end

    assign o_sig_dat    = dat_p1;
    assign o_sig_src    = src_p1;
    assign o_sig_vld    = vld_p1;
    assign o_sig_rdy_i0 = rdy[0];
    assign o_sig_rdy_i1 = rdy[1];
    assign o_cnt_i0     = cnt_p0[0];
    assign o_cnt_i1     = cnt_p0[1];

endmodule

// File: tb/tb_lane_merge2.sv
// Scoreboard bench for lane_merge2: lane drivers feed per-lane expected queues,
// an output monitor pops and compares; directed checks cover timing and state.
module tb_lane_merge2;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] dat0 = '0;
    logic          vld0 = 1'b0;
    logic          rdy0;
    logic [DW-1:0] dat1 = '0;
    logic          vld1 = 1'b0;
    logic          rdy1;
    logic [DW-1:0] o_dat;
    logic          o_src;
    logic          o_vld;
    logic          i_rdy = 1'b1;
    logic [CW-1:0] cnt0;
    logic [CW-1:0] cnt1;

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;
    int t_push = 0;
    bit lat_arm = 1'b0;
    bit log_en  = 1'b0;
    bit acc0    = 1'b0;
    bit acc1    = 1'b0;

    logic [DW-1:0] tx0 [$];
    logic [DW-1:0] tx1 [$];
    logic [DW-1:0] exp0 [$];
    logic [DW-1:0] exp1 [$];
    logic          exp_src [$];
    int            pop_cyc [$];

    lane_merge2 #(.DW(DW), .DEPTH(DEPTH)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_sig_dat_i0 (dat0),
        .i_sig_vld_i0 (vld0),
        .o_sig_rdy_i0 (rdy0),
        .i_sig_dat_i1 (dat1),
        .i_sig_vld_i1 (vld1),
        .o_sig_rdy_i1 (rdy1),
        .o_sig_dat    (o_dat),
        .o_sig_src    (o_src),
        .o_sig_vld    (o_vld),
        .i_sig_rdy    (i_rdy),
        .o_cnt_i0     (cnt0),
        .o_cnt_i1     (cnt1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
        end
    endtask

    // Accepted lane words become expected output words; reset discards them.
    always @(negedge clk) begin
        acc0 = !rst && vld0 && rdy0;
        acc1 = !rst && vld1 && rdy1;
        if (rst) begin
            exp0.delete();
            exp1.delete();
        end
        if (acc0) exp0.push_back(dat0);
        if (acc1) exp1.push_back(dat1);
    end

    // Output monitor.
    always @(negedge clk) begin
        if (!rst && o_vld && i_rdy) begin
            if (log_en) pop_cyc.push_back(cyc);
            if (exp_src.size() > 0) chk("src_order", int'(o_src), int'(exp_src.pop_front()));
            if (!o_src) begin
                if (exp0.size() == 0) begin
                    checks++; errs++;
                    $display("FAIL pop_empty_i0: got 0x%0h want no word", o_dat);
                end else chk("data_i0", int'(o_dat), int'(exp0.pop_front()));
            end else begin
                if (exp1.size() == 0) begin
                    checks++; errs++;
                    $display("FAIL pop_empty_i1: got 0x%0h want no word", o_dat);
                end else chk("data_i1", int'(o_dat), int'(exp1.pop_front()));
            end
        end
    end

    // Lane drivers: present the next queued word once the current one is taken.
    always @(posedge clk) begin
        #1;
        if (acc0 || !vld0) begin
            if (tx0.size() > 0) begin
                if (lat_arm) begin
                    t_push  = cyc;
                    lat_arm = 1'b0;
                end
                dat0 = tx0.pop_front();
                vld0 = 1'b1;
            end else vld0 = 1'b0;
        end
        if (acc1 || !vld1) begin
            if (tx1.size() > 0) begin
                dat1 = tx1.pop_front();
                vld1 = 1'b1;
            end else vld1 = 1'b0;
        end
    end

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 300 && !done; n++) begin
            @(posedge clk);
            #2;
            done = (tx0.size() == 0) && (tx1.size() == 0) && !vld0 && !vld1 &&
                   (exp0.size() == 0) && (exp1.size() == 0) && !o_vld;
        end
        if (!done) begin
            checks++; errs++;
            $display("FAIL drain_timeout: got pending %0d/%0d want 0/0", exp0.size(), exp1.size());
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    initial begin
        int  seen;
        logic [DW-1:0] hold;

        // Reset held 3 cycles with both lanes valid.
        tx0.push_back(8'h01);
        tx1.push_back(8'h02);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_vld",  int'(o_vld), 0);
        chk("rst_dat",  int'(o_dat), 0);
        chk("rst_src",  int'(o_src), 0);
        chk("rst_cnt0", int'(cnt0), 0);
        chk("rst_cnt1", int'(cnt1), 0);
        chk("rst_rdy0", int'(rdy0), 1);
        chk("rst_rdy1", int'(rdy1), 1);
        wait_drain();

        // Single lane: latency and gapless output.
        @(posedge clk); #1;
        log_en  = 1'b1;
        lat_arm = 1'b1;
        tx0.push_back(8'h11); tx0.push_back(8'h22); tx0.push_back(8'h33);
        wait_drain();
        log_en = 1'b0;
        chk("single_cnt", pop_cyc.size(), 3);
        if (pop_cyc.size() == 3) begin
            chk("latency",  pop_cyc[0] - t_push, 2);
            chk("gap_1",    pop_cyc[1] - pop_cyc[0], 1);
            chk("gap_2",    pop_cyc[2] - pop_cyc[0], 2);
        end

        // Contention: fresh arbiter state, strict alternation starting at lane 0.
        pulse_reset();
        for (int k = 0; k < 4; k++) begin
            exp_src.push_back(1'b0);
            exp_src.push_back(1'b1);
            tx0.push_back(8'hA0 + 8'(k));
            tx1.push_back(8'hB0 + 8'(k));
        end
        wait_drain();
        chk("src_left", exp_src.size(), 0);

        // Backpressure: both lanes fill and stall, output holds.
        @(posedge clk); #1 i_rdy = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tx0.push_back(8'h40 + 8'(k));
            tx1.push_back(8'h50 + 8'(k));
        end
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("bp_cnt0", int'(cnt0), 4);
        chk("bp_cnt1", int'(cnt1), 4);
        chk("bp_rdy0", int'(rdy0), 0);
        chk("bp_rdy1", int'(rdy1), 0);
        chk("bp_vld",  int'(o_vld), 1);
        chk("bp_dat",  int'(o_dat), 8'h40);
        chk("bp_src",  int'(o_src), 0);
        hold = o_dat;
        repeat (3) @(negedge clk);
        chk("bp_hold", int'(o_dat), int'(hold));
        @(posedge clk); #1 i_rdy = 1'b1;
        wait_drain();

        // Full lane 1 with alternating downstream ready: count 4,3,4,3...
        @(posedge clk); #1 i_rdy = 1'b0;
        for (int k = 0; k < 12; k++) tx1.push_back(8'h60 + 8'(k));
        repeat (10) @(posedge clk);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1 i_rdy = (k % 2 == 0);
            @(negedge clk);
            chk("osc_cnt1", int'(cnt1), (k % 2 == 0) ? 4 : 3);
            chk("osc_rdy1", int'(rdy1), (k % 2 == 0) ? 0 : 1);
        end
        @(posedge clk); #1 i_rdy = 1'b1;
        wait_drain();

        // Reset mid-stream: buffered words must vanish.
        @(posedge clk); #1 i_rdy = 1'b0;
        for (int k = 0; k < 4; k++) tx0.push_back(8'h70 + 8'(k));
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("mid_pre_vld",  int'(o_vld), 1);
        chk("mid_pre_cnt0", int'(cnt0), 3);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 begin rst = 1'b0; i_rdy = 1'b1; end
        @(negedge clk);
        chk("mid_vld",  int'(o_vld), 0);
        chk("mid_cnt0", int'(cnt0), 0);
        chk("mid_cnt1", int'(cnt1), 0);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (o_vld) seen++;
        end
        chk("mid_no_stale", seen, 0);

        chk("end_exp0", exp0.size(), 0);
        chk("end_exp1", exp1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
